parity_stream_unit: RTL

- Parametrised, registered successor to the team's 3-bit combinational parity generator.
- Accepts a stream of DATA_W-bit words over a valid/ready handshake and computes one parity bit per GROUP_W-bit group, even or odd.
- Optionally checks received parity, flagging and counting errors.
- Sits between a data source and a link or storage interface, as a generator on transmit paths and a checker on receive paths.

---
 rtl/parity_stream_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/parity_stream_unit.sv
// Streaming per-group parity generator/checker with saturating error counter.
// Define PARITY_PIPE_EN for a two-stage pipeline (latency 2); the default build is single-stage.
module parity_stream_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned GROUP_W = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_mode_odd,
  input  logic                        i_chk_en,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [DATA_W-1:0]           i_in_data,
  input  logic [DATA_W/GROUP_W-1:0]   i_in_par,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DATA_W-1:0]           o_out_data,
  output logic [DATA_W/GROUP_W-1:0]   o_out_par,
  output logic [DATA_W/GROUP_W-1:0]   o_out_err,
  output logic [CNT_W-1:0]            o_err_cnt,
  output logic                        o_err_sticky,
  input  logic                        i_err_clr
);

  localparam int unsigned NG = DATA_W / GROUP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_in_ready;
  logic              w_out_xfer;
  logic [NG-1:0]     w_grp_xor;
  logic [NG-1:0]     w_par;
  logic [NG-1:0]     w_err;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [NG-1:0]     r_out_par;
  logic [NG-1:0]     r_out_err;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_err_sticky;

  // Ready depends only on the output register, so a stall never loops back through in_valid.
  assign w_in_ready = !r_out_valid || i_out_ready;
  assign w_out_xfer = r_out_valid && i_out_ready;

  always_comb begin
    w_grp_xor = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      w_grp_xor[g] = ^i_in_data[g*GROUP_W +: GROUP_W];
    end
  end

`ifdef PARITY_PIPE_EN
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic [NG-1:0]     r_s1_xor;
  logic [NG-1:0]     r_s1_in_par;
  logic              r_s1_mode_odd;
  logic              r_s1_chk_en;

  always_comb begin
    w_par = r_s1_xor ^ {NG{r_s1_mode_odd}};
    w_err = r_s1_chk_en ? (w_par ^ r_s1_in_par) : '0;
  end

  // Global stall: both stages move together whenever the output can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_xor      <= '0;
      r_s1_in_par   <= '0;
      r_s1_mode_odd <= 1'b0;
      r_s1_chk_en   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_par     <= '0;
      r_out_err     <= '0;
    end else if (w_in_ready) begin
      r_s1_valid  <= i_in_valid;
      r_out_valid <= r_s1_valid;
      if (i_in_valid) begin
        r_s1_data     <= i_in_data;
        r_s1_xor      <= w_grp_xor;
        r_s1_in_par   <= i_in_par;
        r_s1_mode_odd <= i_mode_odd;
        r_s1_chk_en   <= i_chk_en;
      end
      if (r_s1_valid) begin
        r_out_data <= r_s1_data;
        r_out_par  <= w_par;
        r_out_err  <= w_err;
      end
    end
  end
`else
  always_comb begin
    w_par = w_grp_xor ^ {NG{i_mode_odd}};
    w_err = i_chk_en ? (w_par ^ i_in_par) : '0;
  end

  // Payload loads only on accept so idle-cycle input values never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_par   <= '0;
      r_out_err   <= '0;
    end else if (w_in_ready) begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) begin
        r_out_data <= i_in_data;
        r_out_par  <= w_par;
        r_out_err  <= w_err;
      end
    end
  end
`endif

  // Errors are counted as words leave; a clear on the same edge takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (i_err_clr) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_out_xfer && (|r_out_err)) begin
      r_err_sticky <= 1'b1;
      if (r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_par    = r_out_par;
  assign o_out_err    = r_out_err;
  assign o_err_cnt    = r_err_cnt;
  assign o_err_sticky = r_err_sticky;

endmodule
